// File: rtl/border_link_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : border_link_arbiter
// Description : Round-robin arbiter sharing one tagged 64-bit grid output link
//               between the per-column border FIFOs, with one output register.
// Revision    : 1.0 - initial release
// ============================================================================
module border_link_arbiter #(
    parameter int         NUM_CHANNELS = 10,
    parameter int         DATA_WIDTH   = 15,
    parameter logic [7:0] MSG_TAG      = 8'd6
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_CHANNELS-1:0]            in_valid,
    output logic [NUM_CHANNELS-1:0]            in_ready,
    output logic [63:0]                        out_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic                               busy,
    output logic [15:0]                        words_sent
);

    localparam int CH_BITS = $clog2(NUM_CHANNELS);
    localparam logic [CH_BITS-1:0] c_last_ch = CH_BITS'(NUM_CHANNELS - 1);

    logic [CH_BITS-1:0]      r_last_grant;
    logic [63:0]             r_out_data;
    logic                    r_out_valid;
    logic [15:0]             r_words_sent;

    logic                    w_load;
    logic                    w_any;
    logic                    w_accept;
    logic                    w_handshake;
    logic [NUM_CHANNELS-1:0] w_upper;
    logic [CH_BITS-1:0]      w_winner_upper;
    logic [CH_BITS-1:0]      w_winner_lower;
    logic [CH_BITS-1:0]      w_winner;
    logic [DATA_WIDTH-1:0]   w_payload;
    logic [63:0]             w_word;

    assign w_load      = !r_out_valid || out_ready;
    assign w_any       = |in_valid;
    assign w_handshake = r_out_valid && out_ready;

    // Requests above the last grant take priority; otherwise wrap to the lowest requester.
    always_comb begin
        w_upper        = '0;
        w_winner_upper = '0;
        w_winner_lower = '0;
        for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
            w_upper[i] = in_valid[i] && (CH_BITS'(i) > r_last_grant);
            if (w_upper[i]) begin
                w_winner_upper = CH_BITS'(i);
            end
            if (in_valid[i]) begin
                w_winner_lower = CH_BITS'(i);
            end
        end
        w_winner = (|w_upper) ? w_winner_upper : w_winner_lower;
    end

    always_comb begin
        w_payload = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (w_winner == CH_BITS'(i)) begin
                w_payload = in_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        w_word                   = '0;
        w_word[63:56]            = MSG_TAG;
        w_word[55:48]            = 8'(w_winner);
        w_word[DATA_WIDTH-1:0]   = w_payload;
    end

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            in_ready[i] = !reset && w_load && w_any && (w_winner == CH_BITS'(i));
        end
    end

    assign w_accept = |(in_valid & in_ready);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_words_sent <= '0;
            r_last_grant <= c_last_ch;
        end else begin
            if (w_accept) begin
                r_out_data   <= w_word;
                r_out_valid  <= 1'b1;
                r_last_grant <= w_winner;
            end else if (w_handshake) begin
                r_out_valid  <= 1'b0;
            end
            if (w_handshake) begin
                r_words_sent <= r_words_sent + 16'd1;
            end
        end
    end

    assign out_data   = r_out_data;
    assign out_valid  = r_out_valid;
    assign words_sent = r_words_sent;
    assign busy       = !reset && (r_out_valid || w_any);

endmodule
`default_nettype wire

// File: tb/tb_border_link_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_border_link_arbiter
// Description : Directed, table-driven bench for border_link_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_border_link_arbiter;

    localparam int N  = 10;
    localparam int DW = 15;

    logic            clk = 1'b0;
    logic            reset;
    logic [N*DW-1:0] in_data;
    logic [N-1:0]    in_valid;
    logic [N-1:0]    in_ready;
    logic [63:0]     out_data;
    logic            out_valid;
    logic            out_ready;
    logic            busy;
    logic [15:0]     words_sent;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [N-1:0] iv;
        logic         ordy;
        logic [N-1:0] ir;
        logic         ov;
        int           ch;
        int           words;
    } vec_t;

    vec_t tbl[$];

    border_link_arbiter #(
        .NUM_CHANNELS(N),
        .DATA_WIDTH  (DW),
        .MSG_TAG     (8'd6)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .words_sent(words_sent)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] exp_word(input int ch);
        logic [63:0] w;
        w        = '0;
        w[63:56] = 8'h06;
        w[55:48] = 8'(ch);
        w[14:0]  = 15'(32'h1A3 + ch);
        return w;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [N-1:0] iv, input logic ordy, input logic [N-1:0] ir,
                       input logic ov, input int ch, input int words);
        vec_t v;
        v.iv = iv; v.ordy = ordy; v.ir = ir; v.ov = ov; v.ch = ch; v.words = words;
        tbl.push_back(v);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        in_valid  = '0;
        out_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < N; i++) in_data[i*DW +: DW] = 15'(32'h1A3 + i);

        // Basic transfer, then drain
        add(10'h004, 1'b1, 10'h004, 1'b1, 2, 0);
        add(10'h000, 1'b1, 10'h000, 1'b0, 2, 1);
        // Full fairness: pointer sits at 2, so rotation starts at 3
        for (int k = 0; k < 12; k++) begin
            add(10'h3FF, 1'b1, N'(1) << ((3 + k) % N), 1'b1, (3 + k) % N, 1 + k);
        end
        add(10'h000, 1'b1, 10'h000, 1'b0, 4, 13);
        // Pointer wrap: park on 9, then ch0 before ch9; single requester repeats
        add(10'h200, 1'b1, 10'h200, 1'b1, 9, 13);
        add(10'h201, 1'b1, 10'h001, 1'b1, 0, 14);
        add(10'h200, 1'b1, 10'h200, 1'b1, 9, 15);
        add(10'h200, 1'b1, 10'h200, 1'b1, 9, 16);
        add(10'h000, 1'b1, 10'h000, 1'b0, 9, 17);
        // Backpressure: ch3 wins, holds for 5 cycles, then ch7
        add(10'h088, 1'b0, 10'h008, 1'b1, 3, 17);
        for (int k = 0; k < 5; k++) add(10'h080, 1'b0, 10'h000, 1'b1, 3, 17);
        add(10'h080, 1'b1, 10'h080, 1'b1, 7, 18);
        add(10'h000, 1'b1, 10'h000, 1'b0, 7, 19);

        in_valid  = '0;
        out_ready = 1'b0;
        reset     = 1'b1;
        @(posedge clk); #1;
        check("busy_in_reset_idle", 64'(busy), 64'd0);
        do_reset();
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_out_data", out_data, 64'd0);
        check("reset_words", 64'(words_sent), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);

        for (int r = 0; r < tbl.size(); r++) begin
            in_valid  = tbl[r].iv;
            out_ready = tbl[r].ordy;
            #3;
            check($sformatf("in_ready[%0d]", r), 64'(in_ready), 64'(tbl[r].ir));
            check($sformatf("busy[%0d]", r), 64'(busy), 64'(tbl[r].ov || tbl[r].iv != 0 || out_valid));
            @(posedge clk); #1;
            check($sformatf("out_valid[%0d]", r), 64'(out_valid), 64'(tbl[r].ov));
            check($sformatf("out_data[%0d]", r), out_data, exp_word(tbl[r].ch));
            check($sformatf("words[%0d]", r), 64'(words_sent), 64'(tbl[r].words));
        end
        check("basic_literal_word", exp_word(2), 64'h0602_0000_0000_01A5);

        // Reset while a word is stalled on the link
        in_valid  = 10'h004;
        out_ready = 1'b0;
        @(posedge clk); #1;
        check("stall_valid", 64'(out_valid), 64'd1);
        in_valid = 10'h006;
        reset    = 1'b1;
        #3;
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_words", 64'(words_sent), 64'd0);
        reset = 1'b0;
        #3;
        check("post_rst_grant", 64'(in_ready), 64'h002);

        // Counter wrap: 65536 handshakes from one continuous requester
        do_reset();
        in_valid  = 10'h001;
        out_ready = 1'b1;
        for (int c = 0; c < 65536; c++) begin
            @(posedge clk);
        end
        #1;
        check("words_ffff", 64'(words_sent), 64'hFFFF);
        check("busy_active", 64'(busy), 64'd1);
        in_valid = '0;
        @(posedge clk); #1;
        check("words_wrap", 64'(words_sent), 64'd0);
        check("wrap_out_valid", 64'(out_valid), 64'd0);
        check("busy_idle", 64'(busy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
